writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/pygmy_pkg.sv | 23 ++
 rtl/writeback_unit_if.sv | 35 +++
 rtl/load_align.sv | 41 ++++
 rtl/writeback_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pygmy_pkg.sv
// Shared types for the writeback stage.
// Load width codes, FSM states and the pending-load record.
package pygmy_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr;
  } load_req_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Execute/memory/register-file signal bundle
// around the writeback stage.
interface writeback_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_reg_we;
  logic [4:0]  ex_rd_ptr;
  logic [31:0] ex_alu_res;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_write_en;
  logic [4:0]  rd_ptr;
  logic [31:0] rd;
  logic        busy;
  logic        timeout_err;
  logic        spurious_err;

  modport master (
    output ex_valid, ex_reg_we, ex_rd_ptr,
    output ex_alu_res, ex_is_load, ex_funct3,
    output mem_rvalid, mem_rdata,
    input  ex_ready, reg_write_en, rd_ptr, rd,
    input  busy, timeout_err, spurious_err
  );

  modport slave (
    input  ex_valid, ex_reg_we, ex_rd_ptr,
    input  ex_alu_res, ex_is_load, ex_funct3,
    input  mem_rvalid, mem_rdata,
    output ex_ready, reg_write_en, rd_ptr, rd,
    output busy, timeout_err, spurious_err
  );
endinterface

// File: rtl/load_align.sv
// Load data extraction: picks byte/half from the
// little-endian word by address and extends it.
module load_align
  import pygmy_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16]
                         : word_i[15:0];
  end

  always_comb begin
    unique case (1'b1)
      funct3_i == F3_LB:
        data_o = {{24{byte_sel[7]}}, byte_sel};
      funct3_i == F3_LH:
        data_o = {{16{half_sel[15]}}, half_sel};
      funct3_i == F3_LBU:
        data_o = {24'd0, byte_sel};
      funct3_i == F3_LHU:
        data_o = {16'd0, half_sel};
      default:
        data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results and loads
// into the register file, with load timeout.
module writeback_unit
  import pygmy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_reg_we_i,
  input  logic [4:0]  ex_rd_ptr_i,
  input  logic [31:0] ex_alu_res_i,
  input  logic        ex_is_load_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        reg_write_en_o,
  output logic [4:0]  rd_ptr_o,
  output logic [31:0] rd_o,
  output logic        busy_o,
  output logic        timeout_err_o,
  output logic        spurious_err_o
);

  localparam logic [7:0] CntLast =
    8'(TIMEOUT_CYCLES - 1);

  wb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  load_req_t   req_q, req_d;
  logic        we_q, we_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [31:0] rd_q, rd_d;
  logic        terr_q, terr_d;
  logic        serr_q, serr_d;
  logic [31:0] load_data;

  load_align u_align (
    .funct3_i (req_q.funct3),
    .addr_i   (req_q.addr),
    .word_i   (mem_rdata_i),
    .data_o   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = 1'b0;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    terr_d  = terr_q;
    serr_d  = serr_q;
    unique case (state_q)
      IDLE: begin
        if (mem_rvalid_i) serr_d = 1'b1;
        if (ex_valid_i) begin
          if (ex_is_load_i) begin
            req_d.we     = ex_reg_we_i;
            req_d.rd     = ex_rd_ptr_i;
            req_d.funct3 = ex_funct3_i;
            req_d.addr   = ex_alu_res_i[1:0];
            cnt_d        = 8'd0;
            state_d      = LOAD_WAIT;
          end else begin
            we_d  = ex_reg_we_i && (ex_rd_ptr_i != 5'd0);
            ptr_d = ex_rd_ptr_i;
            rd_d  = ex_alu_res_i;
          end
        end
      end
      LOAD_WAIT: begin
        // Data arriving on the last allowed edge beats the timeout.
        if (mem_rvalid_i) begin
          we_d    = req_q.we && (req_q.rd != 5'd0);
          ptr_d   = req_q.rd;
          rd_d    = load_data;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == CntLast) begin
          terr_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= '0;
      we_q    <= 1'b0;
      ptr_q   <= 5'd0;
      rd_q    <= 32'd0;
      terr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      terr_q  <= terr_d;
      serr_q  <= serr_d;
    end
  end

  assign ex_ready_o     = (state_q == IDLE);
  assign busy_o         = (state_q == LOAD_WAIT);
  assign reg_write_en_o = we_q;
  assign rd_ptr_o       = ptr_q;
  assign rd_o           = rd_q;
  assign timeout_err_o  = terr_q;
  assign spurious_err_o = serr_q;

endmodule
